mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, meaning the main-memory line address width.
REQ-002 SHALL have parameter DATA_W, default 128, meaning the line data width in bits; the mask width is DATA_W/8.
REQ-003 SHALL have port clk input 1, the clock; all logic is posedge clk.
REQ-004 SHALL have port reset input 1, synchronous, active-high.
REQ-005 SHALL have ports ic_req_valid input 1, ic_req_ready output 1 and ic_req_addr input ADDR_W, carrying icache line-read requests.
REQ-006 SHALL have ports ic_resp_valid output 1 and ic_resp_data output DATA_W, carrying icache read returns.
REQ-007 SHALL have ports dc_req_valid input 1, dc_req_ready output 1, dc_req_rw input 1 (1=write), dc_req_addr input ADDR_W, dc_req_data input DATA_W and dc_req_mask input DATA_W/8, carrying dcache requests.
REQ-008 SHALL have ports dc_resp_valid output 1 and dc_resp_data output DATA_W, carrying dcache read returns.
REQ-009 SHALL have ports mem_req_valid output 1, mem_req_ready input 1, mem_req_rw output 1, mem_req_addr output ADDR_W, mem_req_data output DATA_W and mem_req_mask output DATA_W/8, driving main memory.
REQ-010 SHALL have ports mem_resp_valid input 1 and mem_resp_data input DATA_W, carrying main-memory read data.
REQ-011 SHALL have port busy output 1, high whenever the state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE and WAIT_RESP.
REQ-013 In IDLE, SHALL grant one pending requester: assert its *_req_ready for that single cycle, latch its rw/addr/data/mask and owner ID, and go to ISSUE next cycle.
REQ-014 Handshake: a request is accepted only in a cycle where valid && ready are both high; ready SHALL never be high outside IDLE.
REQ-015 In ISSUE, SHALL drive mem_req_valid=1 with the latched fields held stable until the cycle mem_req_ready=1.
REQ-016 On ISSUE acceptance, SHALL go to WAIT_RESP for a read, or to IDLE for a write; writes produce no response.
REQ-017 In WAIT_RESP, on mem_resp_valid=1, SHALL pulse the owner's *_resp_valid for exactly 1 cycle with *_resp_data=mem_resp_data, then go to IDLE.
REQ-018 SHALL ignore mem_resp_valid outside WAIT_RESP.
REQ-019 Response latency SHALL be 0 cycles combinational from mem_resp_valid, or 1 registered cycle; registered (1 cycle) is the required choice.
REQ-020 Request-to-issue latency SHALL be 1 cycle: a grant in cycle N gives mem_req_valid in cycle N+1.
REQ-021 A new grant in IDLE SHALL not occur in the same cycle a response is delivered.
REQ-022 Simultaneous ic and dc valid SHALL be arbitrated per REQ-027/REQ-028.
REQ-023 When the write completes with mem_req_ready in ISSUE, the next IDLE cycle SHALL be eligible to grant.

Reset
REQ-024 On reset, SHALL set state to IDLE and the owner to dcache.
REQ-025 During reset, SHALL hold all outputs at 0: valids, readys, busy, rw, addr, data, mask and resp data.
REQ-026 Reset asserted mid-transaction SHALL abandon the transaction without emitting a response; memory responses arriving after reset are dropped.

Configuration
REQ-027 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy; with it defined, on simultaneous requests the requester not granted last wins (a last-grant flop, reset to icache-last so dcache wins first).
REQ-028 Without ARB_ROUND_ROBIN_EN, dcache SHALL always have fixed priority over icache.

Verification
REQ-029 Reset followed by idle SHALL give all outputs 0 and busy=0.
REQ-030 Icache read 0x0000010, with mem_req_ready=1 and mem_resp_valid 3 cycles later with data 0xDEADBEEF...: SHALL give mem_req_rw=0 and addr 0x0000010, exactly one ic_resp_valid pulse with matching data, and no dc_resp_valid.
REQ-031 Dcache write addr 0x20, mask 0x000F, data 0x55..., with mem_req_ready low for 4 cycles: SHALL hold fields stable through the stall, give rw=1, return to IDLE with no response, and keep busy high throughout.
REQ-032 Simultaneous ic and dc reads, repeated 3 times: without the macro, SHALL grant dc every time, serving ic only when dc is idle; with ARB_ROUND_ROBIN_EN, SHALL alternate the grants dc, ic, dc.
REQ-033 Reset asserted in WAIT_RESP, then mem_resp_valid next cycle: SHALL give no *_resp_valid, state IDLE and busy=0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and main memory.
// The master modport is the arbiter side; the slave modport is the side made
// up of the caches and the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    localparam int MASK_W = DATA_W / 8;

    // icache line-read requests and returns
    logic              ic_req_valid;
    logic              ic_req_ready;
    logic [ADDR_W-1:0] ic_req_addr;
    logic              ic_resp_valid;
    logic [DATA_W-1:0] ic_resp_data;

    // dcache requests and read returns
    logic              dc_req_valid;
    logic              dc_req_ready;
    logic              dc_req_rw;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_data;
    logic [MASK_W-1:0] dc_req_mask;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    // main memory side
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_rw;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_data;
    logic [MASK_W-1:0] mem_req_mask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport master (
        input  ic_req_valid, ic_req_addr,
        input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output ic_req_ready, ic_resp_valid, ic_resp_data,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
    );

    modport slave (
        output ic_req_valid, ic_req_addr,
        output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_data, dc_req_mask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  ic_req_ready, ic_resp_valid, ic_resp_data,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter: the icache (reads only) and the dcache
// (reads and masked writes) share one memory port. One transaction is in
// flight at a time; read data comes back one registered cycle after memory
// returns it.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate between the two
// requesters on collisions; otherwise the dcache always wins.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus,
    output logic          busy
);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic grant_ic;
    logic grant_dc;
    logic dc_first;
    logic issuing;

    // Fields of the granted request, held for the whole transaction
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [MASK_W-1:0] lat_mask;
    logic              owner_ic;

    // Registered read return; while set, the arbiter sits in IDLE without
    // granting so that a grant never lands in the cycle a response goes out
    logic              resp_pending;
    logic [DATA_W-1:0] resp_data_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_ic;

    // Remember which requester was granted last so collisions alternate
    always_ff @(posedge clk) begin
        if (reset) begin
            last_ic <= 1'b1;
        end else if (grant_ic) begin
            last_ic <= 1'b1;
        end else if (grant_dc) begin
            last_ic <= 1'b0;
        end
    end

    assign dc_first = last_ic;
`else
    assign dc_first = 1'b1;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grant selection and next-state decision
    always_comb begin
        state_next = state;
        grant_ic   = 1'b0;
        grant_dc   = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && !resp_pending) begin
                    if (bus.dc_req_valid && (!bus.ic_req_valid || dc_first)) begin
                        grant_dc   = 1'b1;
                        state_next = ISSUE;
                    end else if (bus.ic_req_valid) begin
                        grant_ic   = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_next = lat_rw ? IDLE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (bus.mem_resp_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the winning request and its owner at grant time
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_rw   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_mask <= '0;
            owner_ic <= 1'b0;
        end else if (grant_dc) begin
            lat_rw   <= bus.dc_req_rw;
            lat_addr <= bus.dc_req_addr;
            lat_data <= bus.dc_req_data;
            lat_mask <= bus.dc_req_mask;
            owner_ic <= 1'b0;
        end else if (grant_ic) begin
            lat_rw   <= 1'b0;
            lat_addr <= bus.ic_req_addr;
            lat_data <= '0;
            lat_mask <= '0;
            owner_ic <= 1'b1;
        end
    end

    // Register memory read data; only accepted while a read is outstanding
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_pending <= 1'b0;
            resp_data_q  <= '0;
        end else if (state == WAIT_RESP && bus.mem_resp_valid) begin
            resp_pending <= 1'b1;
            resp_data_q  <= bus.mem_resp_data;
        end else begin
            resp_pending <= 1'b0;
        end
    end

    assign issuing = (state == ISSUE) && !reset;

    assign bus.ic_req_ready  = grant_ic;
    assign bus.dc_req_ready  = grant_dc;

    assign bus.mem_req_valid = issuing;
    assign bus.mem_req_rw    = issuing ? lat_rw   : 1'b0;
    assign bus.mem_req_addr  = issuing ? lat_addr : '0;
    assign bus.mem_req_data  = issuing ? lat_data : '0;
    assign bus.mem_req_mask  = issuing ? lat_mask : '0;

    assign bus.ic_resp_valid = resp_pending && owner_ic && !reset;
    assign bus.dc_resp_valid = resp_pending && !owner_ic && !reset;
    assign bus.ic_resp_data  = bus.ic_resp_valid ? resp_data_q : '0;
    assign bus.dc_resp_data  = bus.dc_resp_valid ? resp_data_q : '0;

    assign busy = (state != IDLE) && !reset;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Read returns are predicted into a
// scoreboard queue when memory data is driven and checked by a monitor when
// a response pulse appears; each scenario task also checks the request side.
module tb_mem_arbiter;
    localparam int ADDR_W = 28;
    localparam int DATA_W = 128;
    localparam int MASK_W = DATA_W / 8;

    typedef struct {
        bit                is_ic;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic clk;
    logic reset;
    logic busy;

    int checks;
    int failures;
    resp_t sb[$];

    mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Step to just after the next rising edge, where inputs are changed
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge, where outputs are observed
    task automatic sample();
        @(negedge clk);
    endtask

    // Response monitor: every pulse must match the oldest predicted return
    always @(negedge clk) begin
        resp_t exp;
        logic [DATA_W-1:0] got;
        if (bus.ic_resp_valid || bus.dc_resp_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_resp ic=%b dc=%b required no response",
                         bus.ic_resp_valid, bus.dc_resp_valid);
            end else begin
                exp = sb.pop_front();
                got = exp.is_ic ? bus.ic_resp_data : bus.dc_resp_data;
                if ({bus.ic_resp_valid, bus.dc_resp_valid} !== {exp.is_ic, !exp.is_ic} ||
                    got !== exp.data) begin
                    failures++;
                    $display("[TB] FAIL resp ic=%b dc=%b data=%h required ic=%b dc=%b data=%h",
                             bus.ic_resp_valid, bus.dc_resp_valid, got,
                             exp.is_ic, !exp.is_ic, exp.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at time %0t required completion", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic clear_inputs();
        bus.ic_req_valid   = 1'b0;
        bus.ic_req_addr    = '0;
        bus.dc_req_valid   = 1'b0;
        bus.dc_req_rw      = 1'b0;
        bus.dc_req_addr    = '0;
        bus.dc_req_data    = '0;
        bus.dc_req_mask    = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        logic [ADDR_W+DATA_W+MASK_W+DATA_W+DATA_W-1:0] fields;
        clear_inputs();
        reset = 1'b1;
        tick();
        bus.ic_req_valid = 1'b1;
        bus.dc_req_valid = 1'b1;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data = {4{32'hA5A5A5A5}};
        tick();
        sample();
        flags = {bus.ic_req_ready, bus.dc_req_ready, bus.mem_req_valid, bus.mem_req_rw,
                 bus.ic_resp_valid, bus.dc_resp_valid, busy, 1'b0};
        fields = {bus.mem_req_addr, bus.mem_req_data, bus.mem_req_mask,
                  bus.ic_resp_data, bus.dc_resp_data};
        checks++;
        if (flags !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_flags got=%b required=00000000", flags);
        end
        checks++;
        if (fields !== '0) begin
            failures++;
            $display("[TB] FAIL reset_fields got nonzero required all zero");
        end
        tick();
        clear_inputs();
        reset = 1'b0;
        sample();
        checks++;
        if ({busy, bus.mem_req_valid, bus.ic_req_ready, bus.dc_req_ready} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL idle_after_reset got=%b required=0000",
                     {busy, bus.mem_req_valid, bus.ic_req_ready, bus.dc_req_ready});
        end
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {4{32'h12345678}};
        tick();
        bus.mem_resp_valid = 1'b0;
        sample();
        checks++;
        if ({bus.ic_resp_valid, bus.dc_resp_valid, busy} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL stray_mem_resp got=%b required=000",
                     {bus.ic_resp_valid, bus.dc_resp_valid, busy});
        end
    endtask

    task automatic test_ic_read();
        resp_t r;
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 28'h0000010;
        sample();
        checks++;
        if ({bus.ic_req_ready, bus.dc_req_ready} !== 2'b10) begin
            failures++;
            $display("[TB] FAIL ic_grant got=%b required=10",
                     {bus.ic_req_ready, bus.dc_req_ready});
        end
        tick();
        bus.ic_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        sample();
        checks++;
        if ({bus.mem_req_valid, bus.mem_req_rw, busy} !== 3'b101 ||
            bus.mem_req_addr !== 28'h0000010) begin
            failures++;
            $display("[TB] FAIL ic_issue valid/rw/busy=%b addr=%h required 101 addr=0000010",
                     {bus.mem_req_valid, bus.mem_req_rw, busy}, bus.mem_req_addr);
        end
        tick();
        bus.mem_req_ready = 1'b0;
        sample();
        checks++;
        if ({busy, bus.mem_req_valid, bus.ic_req_ready} !== 3'b100) begin
            failures++;
            $display("[TB] FAIL ic_wait got busy/valid/ready=%b required=100",
                     {busy, bus.mem_req_valid, bus.ic_req_ready});
        end
        tick();
        tick();
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {4{32'hDEADBEEF}};
        r.is_ic = 1'b1;
        r.data  = {4{32'hDEADBEEF}};
        sb.push_back(r);
        tick();
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        sample();
        checks++;
        if (bus.ic_resp_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ic_resp_timing ic_resp_valid=%b busy=%b required 1 and 0",
                     bus.ic_resp_valid, busy);
        end
        tick();
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL ic_resp_drained pending=%0d required=0", sb.size());
        end
    endtask

    task automatic test_dc_write();
        logic [DATA_W-1:0] wdata;
        logic [1+ADDR_W+DATA_W+MASK_W-1:0] exp_fields;
        wdata = {8{16'h5555}};
        exp_fields = {1'b1, 28'h0000020, wdata, 16'h000F};
        tick();
        bus.dc_req_valid = 1'b1;
        bus.dc_req_rw    = 1'b1;
        bus.dc_req_addr  = 28'h0000020;
        bus.dc_req_data  = wdata;
        bus.dc_req_mask  = 16'h000F;
        sample();
        checks++;
        if ({bus.ic_req_ready, bus.dc_req_ready} !== 2'b01) begin
            failures++;
            $display("[TB] FAIL dc_grant got=%b required=01",
                     {bus.ic_req_ready, bus.dc_req_ready});
        end
        tick();
        bus.dc_req_valid = 1'b0;
        bus.dc_req_data  = '0;
        bus.dc_req_addr  = '0;
        bus.dc_req_mask  = '0;
        bus.mem_req_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            checks++;
            if (bus.mem_req_valid !== 1'b1 || busy !== 1'b1 ||
                {bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_data, bus.mem_req_mask} !== exp_fields) begin
                failures++;
                $display("[TB] FAIL dc_write_stall cycle=%0d valid=%b busy=%b rw=%b addr=%h mask=%h required 1 1 1 0000020 000F",
                         k, bus.mem_req_valid, busy, bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_mask);
            end
            tick();
        end
        bus.mem_req_ready = 1'b1;
        sample();
        checks++;
        if (bus.mem_req_valid !== 1'b1 || busy !== 1'b1 || bus.mem_req_rw !== 1'b1) begin
            failures++;
            $display("[TB] FAIL dc_write_accept valid=%b busy=%b rw=%b required 1 1 1",
                     bus.mem_req_valid, busy, bus.mem_req_rw);
        end
        tick();
        bus.mem_req_ready = 1'b0;
        sample();
        checks++;
        if ({busy, bus.mem_req_valid} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL dc_write_done busy/valid=%b required=00",
                     {busy, bus.mem_req_valid});
        end
        tick();
        tick();
    endtask

    task automatic test_arbitration();
        bit dc_want [4];
        bit dc_win  [4];
        resp_t r;
        logic [ADDR_W-1:0] exp_addr;
        dc_want = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef ARB_ROUND_ROBIN_EN
        dc_win  = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        dc_win  = '{1'b1, 1'b1, 1'b1, 1'b0};
`endif
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.ic_req_valid  = 1'b1;
            bus.ic_req_addr   = 28'h0000100;
            bus.dc_req_valid  = dc_want[i];
            bus.dc_req_rw     = 1'b0;
            bus.dc_req_addr   = 28'h0000200 + 28'(i);
            bus.mem_req_ready = 1'b1;
            sample();
            checks++;
            if ({bus.ic_req_ready, bus.dc_req_ready} !== {!dc_win[i], dc_win[i]}) begin
                failures++;
                $display("[TB] FAIL arb_grant round=%0d ic/dc ready=%b required=%b",
                         i, {bus.ic_req_ready, bus.dc_req_ready}, {!dc_win[i], dc_win[i]});
            end
            exp_addr = dc_win[i] ? (28'h0000200 + 28'(i)) : 28'h0000100;
            tick();
            if (dc_win[i]) bus.dc_req_valid = 1'b0;
            else           bus.ic_req_valid = 1'b0;
            sample();
            checks++;
            if (bus.mem_req_valid !== 1'b1 || bus.mem_req_addr !== exp_addr) begin
                failures++;
                $display("[TB] FAIL arb_issue round=%0d valid=%b addr=%h required 1 addr=%h",
                         i, bus.mem_req_valid, bus.mem_req_addr, exp_addr);
            end
            tick();
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = 128'h1000 + 128'(i);
            r.is_ic = !dc_win[i];
            r.data  = 128'h1000 + 128'(i);
            sb.push_back(r);
            tick();
            bus.mem_resp_valid = 1'b0;
            sample();
            checks++;
            if ({bus.ic_req_ready, bus.dc_req_ready} !== 2'b00) begin
                failures++;
                $display("[TB] FAIL grant_during_resp round=%0d ready=%b required=00",
                         i, {bus.ic_req_ready, bus.dc_req_ready});
            end
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        bus.ic_req_valid = 1'b1;
        bus.ic_req_addr  = 28'h0000300;
        sample();
        checks++;
        if (bus.ic_req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL mid_grant ic_req_ready=%b required=1", bus.ic_req_ready);
        end
        tick();
        bus.ic_req_valid  = 1'b0;
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        sample();
        checks++;
        if (busy !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL mid_wait busy=%b valid=%b required 1 0", busy, bus.mem_req_valid);
        end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = {4{32'hBAD0BAD0}};
        tick();
        bus.mem_resp_valid = 1'b0;
        sample();
        checks++;
        if ({bus.ic_resp_valid, bus.dc_resp_valid, busy, bus.mem_req_valid} !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL mid_reset_drop resp ic/dc busy valid=%b required=0000",
                     {bus.ic_resp_valid, bus.dc_resp_valid, busy, bus.mem_req_valid});
        end
        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("[TB] FAIL final_scoreboard pending=%0d required=0", sb.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_ic_read();
        test_dc_write();
        test_arbitration();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
